updown_count_decoder: RTL and testbench

- Receiving end of the up/down counter interface: samples a free-running WIDTH-bit up/down count and recovers step events, direction, wrap-around and direction reversals.
- Accumulates a wider signed-agnostic position from the recovered steps.
- Used by downstream VGA logic (pattern/scroll control) that needs per-step pulses instead of raw count values.
- Flags illegal multi-step jumps so a count source that skips values is detected.

---
 rtl/updown_count_decoder_if.sv | 46 ++++
 rtl/updown_count_decoder.sv | 100 ++++++++++
 tb/tb_updown_count_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/updown_count_decoder_if.sv
// Sampled count input and decoded step outputs of the up/down count decoder.
// master drives the count side, slave is the decoder.
interface updown_count_decoder_if #(
  parameter int WIDTH     = 3,
  parameter int POS_WIDTH = 16
);
  logic                 clear;
  logic                 sample_valid;
  logic [WIDTH-1:0]     count_in;
  logic                 locked;
  logic                 step_up;
  logic                 step_down;
  logic                 wrap;
  logic                 reversal;
  logic                 jump_error;
  logic                 direction;
  logic [POS_WIDTH-1:0] position;

  modport master (
    output clear,
    output sample_valid,
    output count_in,
    input  locked,
    input  step_up,
    input  step_down,
    input  wrap,
    input  reversal,
    input  jump_error,
    input  direction,
    input  position
  );

  modport slave (
    input  clear,
    input  sample_valid,
    input  count_in,
    output locked,
    output step_up,
    output step_down,
    output wrap,
    output reversal,
    output jump_error,
    output direction,
    output position
  );
endinterface

// File: rtl/updown_count_decoder.sv
// Recovers step pulses, direction, wrap and reversal from a sampled
// up/down count and accumulates them into a wider position.
module updown_count_decoder #(
  parameter int WIDTH     = 3,
  parameter int POS_WIDTH = 16
) (
  input logic                   clock,
  input logic                   reset,
  updown_count_decoder_if.slave bus
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [WIDTH-1:0] MAXC = '1;

  state_t               state;
  logic [WIDTH-1:0]     last_count;
  logic                 have_step;
  logic                 dir_q;
  logic [POS_WIDTH-1:0] pos_q;
  logic                 up_q;
  logic                 down_q;
  logic                 wrap_q;
  logic                 rev_q;
  logic                 jerr_q;
  logic [WIDTH-1:0]     delta;

  assign delta = bus.count_in - last_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= UNLOCKED;
      last_count <= '0;
      have_step  <= 1'b0;
      dir_q      <= 1'b0;
      pos_q      <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      wrap_q     <= 1'b0;
      rev_q      <= 1'b0;
      jerr_q     <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      wrap_q <= 1'b0;
      rev_q  <= 1'b0;
      jerr_q <= 1'b0;
      if (bus.clear) begin
        state      <= UNLOCKED;
        last_count <= '0;
        have_step  <= 1'b0;
        dir_q      <= 1'b0;
        pos_q      <= '0;
      end else if (bus.sample_valid) begin
        unique case (state)
          UNLOCKED: begin
            last_count <= bus.count_in;
            state      <= LOCKED;
          end
          LOCKED: begin
            unique case (1'b1)
              (delta == '0): ;
              (delta == WIDTH'(1)): begin
                up_q       <= 1'b1;
                wrap_q     <= (last_count == MAXC);
                rev_q      <= have_step & dir_q;
                pos_q      <= pos_q + POS_WIDTH'(1);
                dir_q      <= 1'b0;
                have_step  <= 1'b1;
                last_count <= bus.count_in;
              end
              (delta == MAXC): begin
                down_q     <= 1'b1;
                wrap_q     <= (last_count == '0);
                rev_q      <= have_step & ~dir_q;
                pos_q      <= pos_q - POS_WIDTH'(1);
                dir_q      <= 1'b1;
                have_step  <= 1'b1;
                last_count <= bus.count_in;
              end
              // skipped values: resync only, keep step history
              default: begin
                jerr_q     <= 1'b1;
                last_count <= bus.count_in;
              end
            endcase
          end
        endcase
      end
    end
  end

  assign bus.locked     = (state == LOCKED);
  assign bus.step_up    = up_q;
  assign bus.step_down  = down_q;
  assign bus.wrap       = wrap_q;
  assign bus.reversal   = rev_q;
  assign bus.jump_error = jerr_q;
  assign bus.direction  = dir_q;
  assign bus.position   = pos_q;
endmodule

// File: tb/tb_updown_count_decoder.sv
// Scoreboard bench for updown_count_decoder: directed vectors push
// expected outputs, a monitor pops and compares one per clock.
module tb_updown_count_decoder;
  localparam int W  = 3;
  localparam int PW = 16;

  typedef struct packed {
    logic          lk;
    logic          up;
    logic          dn;
    logic          wr;
    logic          rv;
    logic          je;
    logic          dir;
    logic [PW-1:0] pos;
  } obs_t;

  logic clock = 1'b0;
  logic reset;

  updown_count_decoder_if #(.WIDTH(W), .POS_WIDTH(PW)) bus ();

  updown_count_decoder #(.WIDTH(W), .POS_WIDTH(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  obs_t exp_q[$];
  int   tag_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;
  obs_t mon_w;
  int   mon_t;

  function automatic obs_t observe();
    observe = {bus.locked, bus.step_up, bus.step_down, bus.wrap,
               bus.reversal, bus.jump_error, bus.direction,
               bus.position};
  endfunction

  // flags order: locked, up, down, wrap, reversal, jump, direction
  function automatic obs_t mk(input logic [6:0] f, input int pos);
    mk = {f, PW'(pos)};
  endfunction

  task automatic check(input string name, input obs_t got,
                       input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic vec(input logic clr, input logic v,
                     input logic [W-1:0] c, input obs_t want);
    @(negedge clock);
    bus.clear        = clr;
    bus.sample_valid = v;
    bus.count_in     = c;
    exp_q.push_back(want);
    tag_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic drain();
    int guard;
    @(negedge clock);
    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
  endtask

  always begin
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      mon_w = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      check($sformatf("vec%0d", mon_t), observe(), mon_w);
    end
  end

  initial begin
    logic [W-1:0] c;
    reset            = 1'b1;
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.count_in     = '0;
    #12;
    check("reset_state", observe(), mk(7'b0000000, 0));
    @(negedge clock);
    reset = 1'b0;

    // lock at 5
    vec(0, 1, 3'd5, mk(7'b1000000, 0));
    // four ups, wrap on 7->0
    vec(0, 1, 3'd6, mk(7'b1100000, 1));
    vec(0, 1, 3'd7, mk(7'b1100000, 2));
    vec(0, 1, 3'd0, mk(7'b1101000, 3));
    vec(0, 1, 3'd1, mk(7'b1100000, 4));
    // down (reverses the up run), down+wrap, up+wrap+reversal
    vec(0, 1, 3'd0, mk(7'b1010101, 3));
    vec(0, 1, 3'd7, mk(7'b1011001, 2));
    vec(0, 1, 3'd0, mk(7'b1101100, 3));
    // up to 3, jump to 6, then up to 7
    vec(0, 1, 3'd1, mk(7'b1100000, 4));
    vec(0, 1, 3'd2, mk(7'b1100000, 5));
    vec(0, 1, 3'd3, mk(7'b1100000, 6));
    vec(0, 1, 3'd6, mk(7'b1000010, 6));
    vec(0, 1, 3'd7, mk(7'b1100000, 7));
    // down, jump keeps direction and history, down again no reversal
    vec(0, 1, 3'd6, mk(7'b1010101, 6));
    vec(0, 1, 3'd2, mk(7'b1000011, 6));
    vec(0, 1, 3'd1, mk(7'b1010001, 5));
    // idle and zero delta
    vec(0, 0, 3'd3, mk(7'b1000001, 5));
    vec(0, 1, 3'd1, mk(7'b1000001, 5));
    // clear beats sample_valid, relock, first step no reversal
    vec(1, 1, 3'd2, mk(7'b0000000, 0));
    vec(0, 1, 3'd3, mk(7'b1000000, 0));
    vec(0, 1, 3'd2, mk(7'b1010001, 'hFFFF));
    vec(0, 1, 3'd3, mk(7'b1100100, 0));
    // sixteen ups to position 0x0010
    for (int i = 1; i <= 16; i++) begin
      c = W'((3 + i) % 8);
      vec(0, 1, c, mk({3'b110, c == 3'd0, 3'b000}, i));
    end
    drain();
    check("pre_reset", observe(), mk(7'b1000000, 16));
    #1 reset = 1'b1;
    #1;
    check("async_reset", observe(), mk(7'b0000000, 0));
    @(negedge clock);
    reset = 1'b0;

    // full position wrap
    vec(0, 1, 3'd0, mk(7'b1000000, 0));
    for (int i = 1; i <= 65536; i++) begin
      c = W'(i % 8);
      vec(0, 1, c, mk({3'b110, c == 3'd0, 3'b000}, i));
    end
    drain();
    check("pos_wrap", observe(), mk(7'b1000000, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
